hilo_divider: RTL and testbench

//  Iterative execute-stage divider that owns the HI/LO registers. Consumes the

---
 rtl/hilo_divider_pkg.sv | 14 +
 rtl/hilo_divider_div_step.sv | 29 ++
 rtl/hilo_divider.sv | 103 ++++++++++
 tb/tb_hilo_divider.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_divider_pkg.sv
// Shared encodings for the HI/LO divider: FSM states and the DIV/DIVU funct codes.
// The DIVU funct code feeds the optional unsigned-divide build (HILO_DIVU_EN).
package hilo_divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  localparam logic [5:0] FUNCT_DIV  = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU = 6'h1b;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep or restore.
module hilo_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Partial remainder stays below the divisor, so WIDTH+1 bits never wrap.
  always_comb begin
    trial = {rem, q[WIDTH-1]};
    diff  = trial - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = trial[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_divider.sv
// Iterative execute-stage divider owning HI/LO; one quotient bit per cycle.
// Optional macro HILO_DIVU_EN adds the div_signed port for DIVU support.
module hilo_divider
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             div_start,
`ifdef HILO_DIVU_EN
  input  logic             div_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_read,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             neg_quo_q, neg_rem_q;
  logic             is_signed;
  logic             accept;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

`ifdef HILO_DIVU_EN
  assign is_signed = div_signed;
`else
  assign is_signed = 1'b1;
`endif

  assign accept = (state_q == DIV_IDLE) && div_start;

  hilo_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q        (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_step),
    .q_next   (quo_step)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (div_start) state_d = DIV_RUN;
      DIV_RUN:  if (cnt_q == '0) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign busy  = (state_q != DIV_IDLE);
  assign done  = (state_q == DIV_FIX);
  assign stall = (mf_read | div_start) & busy;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_W'(WIDTH - 1);
      end else if ((state_q == DIV_RUN) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == DIV_FIX) begin
        lo <= cond_neg(quo_q, neg_quo_q);
        hi <= cond_neg(rem_q, neg_rem_q);
      end
    end
  end

  // Operand magnitudes and result signs are captured at start; the quotient
  // register initially holds the dividend and fills with quotient bits.
  always_ff @(posedge clock) begin
    if (accept) begin
      quo_q     <= cond_neg(dividend, is_signed & dividend[WIDTH-1]);
      dvs_q     <= cond_neg(divisor, is_signed & divisor[WIDTH-1]);
      rem_q     <= '0;
      neg_quo_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem_q <= is_signed & dividend[WIDTH-1];
    end else if (state_q == DIV_RUN) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
    end
  end

endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: arithmetic reference model plus a
// per-cycle compare of busy/done/stall/hi/lo, directed cases and random divides.
module tb_hilo_divider;
  import hilo_divider_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n, div_start, mf_read;
  logic [W-1:0] dividend, divisor;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;
  logic         cur_sgn;
`ifdef HILO_DIVU_EN
  logic [5:0]   funct;
  logic         div_signed;
  assign div_signed = (funct != FUNCT_DIVU);
`endif

  int           n_checks = 0;
  int           n_fail = 0;
  bit           chk_en = 1'b0;
  int           remaining = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;

  hilo_divider #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .div_start  (div_start),
`ifdef HILO_DIVU_EN
    .div_signed (div_signed),
`endif
    .dividend   (dividend),
    .divisor    (divisor),
    .mf_read    (mf_read),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference divide: truncating division on magnitudes, divide-by-zero gives
  // all-ones quotient and the dividend magnitude as remainder, then signs.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sgn, output logic [W-1:0] q,
                                  output logic [W-1:0] r);
    logic [W-1:0] ua, ub;
    logic         nq, nr;
    nr = sgn && a[W-1];
    nq = sgn && (a[W-1] ^ b[W-1]);
    ua = nr ? -a : a;
    ub = (sgn && b[W-1]) ? -b : b;
    if (ub == '0) begin
      q = '1;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (nq) q = -q;
    if (nr) r = -r;
  endfunction

  // Timeline model: an accepted divide occupies WIDTH+1 busy cycles, the last
  // one being the done cycle; results appear after it.
  always @(posedge clock) begin
    if (!reset_n) begin
      remaining = 0;
      exp_hi    = '0;
      exp_lo    = '0;
    end else if (remaining == 0) begin
      if (div_start) begin
        ref_div(dividend, divisor, cur_sgn, pend_lo, pend_hi);
        remaining = W + 1;
      end
    end else begin
      remaining--;
      if (remaining == 0) begin
        exp_hi = pend_hi;
        exp_lo = pend_lo;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, remaining != 0});
      chk("done", {31'b0, done}, {31'b0, remaining == 1});
      chk("stall", {31'b0, stall}, {31'b0, (mf_read | div_start) && (remaining != 0)});
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic was_idle;
    int   k;
    dividend = a;
    divisor  = b;
`ifdef HILO_DIVU_EN
    cur_sgn  = s;
    funct    = s ? FUNCT_DIV : FUNCT_DIVU;
`else
    cur_sgn  = 1'b1 | s;
`endif
    div_start = 1'b1;
    k = 0;
    do begin
      was_idle = !busy;
      @(posedge clock);
      #1;
      k++;
    end while (!was_idle && k < 200);
    if (!was_idle) chk("issue accept", {31'b0, was_idle}, 32'd1);
    div_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int bc, output int da);
    bc = 0;
    da = 0;
    while (busy === 1'b1 && bc < budget) begin
      bc++;
      if (done) da = bc;
      @(posedge clock);
      #1;
    end
    if (busy !== 1'b0) chk("wait idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] q, r, a, b;
    int           bc, da, gap, sel;
    logic         s;

    reset_n = 1'b0; div_start = 1'b0; mf_read = 1'b0;
    dividend = '0; divisor = '0; cur_sgn = 1'b1;
`ifdef HILO_DIVU_EN
    funct = FUNCT_DIV;
`endif

    ref_div(32'd100, 32'd7, 1'b1, q, r);
    chk("ref 100/7 lo", q, 32'd14);           chk("ref 100/7 hi", r, 32'd2);
    ref_div(32'hFFFFFF9C, 32'd7, 1'b1, q, r);
    chk("ref -100/7 lo", q, 32'hFFFFFFF2);    chk("ref -100/7 hi", r, 32'hFFFFFFFE);
    ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1, q, r);
    chk("ref ovf lo", q, 32'h80000000);       chk("ref ovf hi", r, 32'd0);
    ref_div(32'd7, 32'd0, 1'b1, q, r);
    chk("ref 7/0 lo", q, 32'hFFFFFFFF);       chk("ref 7/0 hi", r, 32'd7);
    ref_div(32'hFFFFFFFE, 32'd2, 1'b0, q, r);
    chk("ref divu lo", q, 32'h7FFFFFFF);      chk("ref divu hi", r, 32'd0);

    @(posedge clock);
    chk_en = 1'b1;
    @(posedge clock);
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset hi", hi, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    issue(32'd100, 32'd7, 1'b1);
    wait_idle(200, bc, da);
    chk("t1 busy cycles", bc, 32'd33);
    chk("t1 done cycle", da, 32'd33);
    chk("t1 lo", lo, 32'd14);
    chk("t1 hi", hi, 32'd2);

    issue(32'hFFFFFF9C, 32'd7, 1'b1);
    mf_read = 1'b1;
    wait_idle(200, bc, da);
    chk("t4 stall released", {31'b0, stall}, 32'd0);
    chk("t2 lo", lo, 32'hFFFFFFF2);
    chk("t2 hi", hi, 32'hFFFFFFFE);
    mf_read = 1'b0;

    issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle(200, bc, da);
    chk("t3 ovf lo", lo, 32'h80000000);
    chk("t3 ovf hi", hi, 32'd0);
    issue(32'd5, 32'd0, 1'b1);
    issue(32'hFFFFFFFE, 32'd2, 1'b0);
    chk("back-to-back busy", {31'b0, busy}, 32'd1);
    issue(32'd9, 32'd4, 1'b1);
    wait_idle(200, bc, da);
    chk("t3 9/4 lo", lo, 32'd2);
    chk("t3 9/4 hi", hi, 32'd1);

    issue(32'hFFFFFFFE, 32'd2, 1'b0);
    wait_idle(200, bc, da);
`ifdef HILO_DIVU_EN
    chk("t6 divu lo", lo, 32'h7FFFFFFF);
`else
    chk("t6 signed lo", lo, 32'hFFFFFFFF);
`endif
    chk("t6 hi", hi, 32'd0);

    issue(32'd100, 32'd7, 1'b1);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("t5 busy", {31'b0, busy}, 32'd0);
    chk("t5 done", {31'b0, done}, 32'd0);
    chk("t5 lo", lo, 32'd0);
    chk("t5 hi", hi, 32'd0);
    repeat (40) begin
      @(posedge clock);
      #1;
    end

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 7);
      a = $urandom();
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFFFFFF :
          (sel == 2) ? W'($urandom_range(1, 15)) : $urandom();
      if (sel == 3) a = 32'h80000000;
      if (sel == 4) b = b >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      issue(a, b, s);
      gap = $urandom_range(0, 40);
      repeat (gap) begin
        mf_read = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
      end
      mf_read = 1'b0;
    end
    wait_idle(200, bc, da);
    repeat (3) begin
      @(posedge clock);
      #1;
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
